// File: rtl/card_shuffler.sv
// card_shuffler: turns a free-running random word stream into a uniformly
// shuffled deck of NCARDS card IDs (Fisher-Yates with rejection sampling).
// Optional macro SHUFFLE_REJECT_LIMIT_EN bounds each shuffle step to 8 cycles
// by force-accepting on the 8th consecutive rejection.
//
// Handshake: pulse start while idle or done; busy is high while the deck is
// being rebuilt and shuffled; done is a level that stays high until the next
// accepted start. start is ignored while busy. Never busy and done together.
module card_shuffler #(
  parameter int NCARDS = 21,
  parameter int IDXW   = 5,
  parameter int RW     = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [RW-1:0]   rand_in,
  input  logic [IDXW-1:0] rd_addr,
  output logic [IDXW-1:0] rd_data,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INIT = 2'd1,
    S_SHUF = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [IDXW-1:0] LAST = IDXW'(NCARDS - 1);
  localparam logic [IDXW-1:0] ONE  = IDXW'(1);

  state_t          state;
  state_t          state_next;

  // idx is the write pointer k during INIT and the Fisher-Yates index i in SHUF
  logic [IDXW-1:0] idx;
  logic [IDXW-1:0] deck [NCARDS];

  logic [IDXW-1:0] mask;
  logic [IDXW-1:0] jraw;
  logic [IDXW-1:0] jsel;
  logic            in_range;
  logic            accept;
  logic            start_go;
  logic            shuf_step;
  logic [IDXW-1:0] deck_i;
  logic [IDXW-1:0] deck_j;

  // Only the low IDXW bits of the random word are consumed
  logic            unused_rand_bits;
  assign unused_rand_bits = ^rand_in[RW-1:IDXW];

  // Mask covers every bit position up to the MSB set in idx
  always_comb begin
    mask = '0;
    for (int b = 0; b < IDXW; b++) begin
      mask[b] = ((idx >> b) != '0);
    end
  end

  assign jraw     = rand_in[IDXW-1:0] & mask;
  assign in_range = (jraw <= idx);

`ifdef SHUFFLE_REJECT_LIMIT_EN
  logic [2:0] rej_cnt;
  logic       force_acc;

  assign force_acc = !in_range && (rej_cnt == 3'd7);
  assign accept    = in_range || force_acc;
  // jraw <= mask <= 2*idx+1, so folding down by idx+1 always lands in 0..idx
  assign jsel      = in_range ? jraw : (jraw - (idx + ONE));

  // Consecutive-rejection counter, cleared on each accept and on SHUF entry
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rej_cnt <= 3'd0;
    end else if (state == S_INIT || start_go) begin
      rej_cnt <= 3'd0;
    end else if (state == S_SHUF) begin
      if (accept) rej_cnt <= 3'd0;
      else        rej_cnt <= rej_cnt + 3'd1;
    end
  end
`else
  assign accept = in_range;
  assign jsel   = jraw;
`endif

  assign start_go  = start && (state == S_IDLE || state == S_DONE);
  assign shuf_step = (state == S_SHUF) && accept;

  // Current contents at the two swap positions
  always_comb begin
    deck_i = '0;
    deck_j = '0;
    for (int k = 0; k < NCARDS; k++) begin
      if (IDXW'(k) == idx)  deck_i = deck[k];
      if (IDXW'(k) == jsel) deck_j = deck[k];
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_INIT;
      S_INIT:  if (idx == LAST) state_next = S_SHUF;
      S_SHUF:  if (accept && idx == ONE) state_next = S_DONE;
      S_DONE:  if (start) state_next = S_INIT;
      default: state_next = S_IDLE;
    endcase
  end

  // Status outputs decoded from state, so they follow reset immediately
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_INIT:  busy = 1'b1;
      S_SHUF:  busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Index: counts up through INIT, then down one per accepted swap
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx <= '0;
    end else if (start_go) begin
      idx <= '0;
    end else if (state == S_INIT) begin
      idx <= (idx == LAST) ? LAST : (idx + ONE);
    end else if (shuf_step) begin
      idx <= idx - ONE;
    end
  end

  // Deck storage: identity on reset and INIT, two-entry swap on accept
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NCARDS; k++) deck[k] <= IDXW'(k);
    end else if (state == S_INIT) begin
      for (int k = 0; k < NCARDS; k++) begin
        if (IDXW'(k) == idx) deck[k] <= IDXW'(k);
      end
    end else if (shuf_step) begin
      for (int k = 0; k < NCARDS; k++) begin
        if (IDXW'(k) == idx)       deck[k] <= deck_j;
        else if (IDXW'(k) == jsel) deck[k] <= deck_i;
      end
    end
  end

  // Combinational read port; out-of-deck addresses read as 0
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < NCARDS; k++) begin
      if (rd_addr == IDXW'(k)) rd_data = deck[k];
    end
  end

endmodule

// File: tb/tb_card_shuffler.sv
// tb_card_shuffler: self-checking bench for card_shuffler. A Fisher-Yates
// reference model replays the exact random words presented at each clock
// edge and predicts the final deck and the edge on which done rises.
// Honours SHUFFLE_REJECT_LIMIT_EN the same way as the design.
module tb_card_shuffler;

  localparam int NCARDS = 21;
  localparam int IDXW   = 5;
  localparam int RW     = 32;

  logic            clk;
  logic            reset;
  logic            start;
  logic [RW-1:0]   rand_in;
  logic [IDXW-1:0] rd_addr;
  logic [IDXW-1:0] rd_data;
  logic            busy;
  logic            done;

  int n_checks;
  int n_fail;

  logic [31:0]     word_q[$];
  logic [IDXW-1:0] exp_q[$];
  logic [IDXW-1:0] got_deck [NCARDS];
  int              model_edge;
  logic [31:0]     lfsr;
  bit              both_seen;
  logic            busy_at_start;
  logic            done_at_start;

  card_shuffler #(.NCARDS(NCARDS), .IDXW(IDXW), .RW(RW)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .rand_in (rand_in),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .busy    (busy),
    .done    (done)
  );

  // Clock and global watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (busy && done) both_seen = 1'b1;
  endtask

  task automatic get_word(input int mode, input logic [31:0] cval, output logic [31:0] w);
    if (mode == 0) begin
      w = cval;
    end else if (mode == 1) begin
      lfsr = lfsr[0] ? ((lfsr >> 1) ^ 32'hA3000000) : (lfsr >> 1);
      w = lfsr;
    end else begin
      w = $urandom;
    end
  endtask

  // Start (optionally) and clock a shuffle, recording the word seen at each edge
  task automatic run_shuffle(input bit do_start, input int mode, input logic [31:0] cval,
                             input int budget, input int restart_at, output int dut_edge);
    logic [31:0] w;
    int base;
    if (do_start) begin
      word_q.delete();
      get_word(mode, cval, w);
      rand_in = w;
      start = 1'b1;
      tick();
      start = 1'b0;
      busy_at_start = busy;
      done_at_start = done;
    end
    base = word_q.size();
    dut_edge = -1;
    for (int n = base + 1; n <= base + budget; n++) begin
      get_word(mode, cval, w);
      rand_in = w;
      word_q.push_back(w);
      start = (n == restart_at);
      tick();
      if (done) begin
        dut_edge = n;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic read_deck();
    for (int k = 0; k < NCARDS; k++) begin
      rd_addr = IDXW'(k);
      #1;
      got_deck[k] = rd_data;
    end
  endtask

  // ---------------- reference model ----------------
  // Edges 1..NCARDS rebuild the deck; every later edge consumes one word.
  task automatic model_shuffle();
    int d [NCARDS];
    int pos, m, jr, j, t, rej;
    logic [31:0] w;
    bit ok;
    for (int k = 0; k < NCARDS; k++) d[k] = k;
    pos = NCARDS;
    ok = 1'b1;
    for (int i = NCARDS - 1; i >= 1 && ok; i--) begin
      rej = 0;
      m = 1;
      while (m < i) m = m * 2 + 1;
      forever begin
        if (pos >= word_q.size()) begin
          ok = 1'b0;
          break;
        end
        w = word_q[pos];
        pos++;
        jr = int'(w[IDXW-1:0]) & m;
        j = -1;
        if (jr <= i) begin
          j = jr;
        end else begin
          rej++;
`ifdef SHUFFLE_REJECT_LIMIT_EN
          if (rej == 8) j = jr - (i + 1);
`endif
        end
        if (j >= 0) begin
          t = d[i];
          d[i] = d[j];
          d[j] = t;
          break;
        end
      end
    end
    model_edge = ok ? pos : -1;
    exp_q.delete();
    for (int k = 0; k < NCARDS; k++) exp_q.push_back(IDXW'(d[k]));
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int e;
    reset = 1'b1; start = 1'b0; rand_in = '0; rd_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_status: got busy=%b done=%b expected 0 0", busy, done);
    end
    rd_addr = 5'd7; #1;
    n_checks++;
    if (rd_data !== 5'd7) begin
      n_fail++;
      $display("FAIL reset_rd7: got %0d expected 7", rd_data);
    end
    reset = 1'b0;
    // Abort a shuffle well inside SHUF with a reset asserted mid-cycle
    run_shuffle(1'b1, 0, 32'h0, 30, 0, e);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midshuf_busy: got %b expected 1", busy);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset_status: got busy=%b done=%b expected 0 0", busy, done);
    end
    rd_addr = 5'd7; #1;
    n_checks++;
    if (rd_data !== 5'd7) begin
      n_fail++;
      $display("FAIL async_reset_rd7: got %0d expected 7", rd_data);
    end
    rd_addr = 5'd25; #1;
    n_checks++;
    if (rd_data !== 5'd0) begin
      n_fail++;
      $display("FAIL async_reset_rd25: got %0d expected 0", rd_data);
    end
    rd_addr = 5'd20; #1;
    n_checks++;
    if (rd_data !== 5'd20) begin
      n_fail++;
      $display("FAIL async_reset_rd20: got %0d expected 20", rd_data);
    end
    #1 reset = 1'b0;
  endtask

  task automatic test_const_zero();
    int e;
    logic [IDXW-1:0] ex;
    run_shuffle(1'b1, 0, 32'h0, 100, 0, e);
    n_checks++;
    if (busy_at_start !== 1'b1 || done_at_start !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_start_status: got busy=%b done=%b expected 1 0", busy_at_start, done_at_start);
    end
    n_checks++;
    if (e !== 41) begin
      n_fail++;
      $display("FAIL zero_latency: got %0d expected 41", e);
    end
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_busy_done: got %b expected 0", busy);
    end
    read_deck();
    for (int k = 0; k < NCARDS; k++) begin
      ex = (k == 0) ? IDXW'(1) : (k == NCARDS - 1) ? IDXW'(0) : IDXW'(k + 1);
      n_checks++;
      if (got_deck[k] !== ex) begin
        n_fail++;
        $display("FAIL zero_deck[%0d]: got %0d expected %0d", k, got_deck[k], ex);
      end
    end
  endtask

  task automatic test_const_one();
    int e;
    logic [IDXW-1:0] ex;
    run_shuffle(1'b1, 0, 32'h1, 100, 0, e);
    n_checks++;
    if (e !== 41) begin
      n_fail++;
      $display("FAIL one_latency: got %0d expected 41", e);
    end
    read_deck();
    for (int k = 0; k < NCARDS; k++) begin
      ex = (k == 0) ? IDXW'(0) : (k == NCARDS - 1) ? IDXW'(1) : IDXW'(k + 1);
      n_checks++;
      if (got_deck[k] !== ex) begin
        n_fail++;
        $display("FAIL one_deck[%0d]: got %0d expected %0d", k, got_deck[k], ex);
      end
    end
  endtask

  task automatic test_restart();
    int e;
    logic [IDXW-1:0] ex;
    run_shuffle(1'b1, 0, 32'h0, 100, 10, e);
    n_checks++;
    if (e !== 41) begin
      n_fail++;
      $display("FAIL restart_latency: got %0d expected 41", e);
    end
    read_deck();
    for (int k = 0; k < NCARDS; k++) begin
      ex = (k == 0) ? IDXW'(1) : (k == NCARDS - 1) ? IDXW'(0) : IDXW'(k + 1);
      n_checks++;
      if (got_deck[k] !== ex) begin
        n_fail++;
        $display("FAIL restart_deck[%0d]: got %0d expected %0d", k, got_deck[k], ex);
      end
    end
    // Start from DONE, then abort with reset 20 cycles in
    run_shuffle(1'b1, 0, 32'h0, 19, 0, e);
    n_checks++;
    if (busy_at_start !== 1'b1 || done_at_start !== 1'b0) begin
      n_fail++;
      $display("FAIL from_done_status: got busy=%b done=%b expected 1 0", busy_at_start, done_at_start);
    end
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_status: got busy=%b done=%b expected 0 0", busy, done);
    end
    read_deck();
    for (int k = 0; k < NCARDS; k++) begin
      n_checks++;
      if (got_deck[k] !== IDXW'(k)) begin
        n_fail++;
        $display("FAIL abort_deck[%0d]: got %0d expected %0d", k, got_deck[k], k);
      end
    end
    @(negedge clk) reset = 1'b0;
  endtask

  task automatic test_stuck();
    int e;
`ifdef SHUFFLE_REJECT_LIMIT_EN
    run_shuffle(1'b1, 0, 32'h1F, 28, 0, e);
    rd_addr = 5'd20; #1;
    n_checks++;
    if (rd_data !== 5'd20) begin
      n_fail++;
      $display("FAIL stuck_pre_force: got %0d expected 20", rd_data);
    end
    run_shuffle(1'b0, 0, 32'h1F, 1, 0, e);
    rd_addr = 5'd20; #1;
    n_checks++;
    if (rd_data !== 5'd10) begin
      n_fail++;
      $display("FAIL stuck_force_d20: got %0d expected 10", rd_data);
    end
    rd_addr = 5'd10; #1;
    n_checks++;
    if (rd_data !== 5'd20) begin
      n_fail++;
      $display("FAIL stuck_force_d10: got %0d expected 20", rd_data);
    end
    run_shuffle(1'b0, 0, 32'h1F, 300, 0, e);
    model_shuffle();
    n_checks++;
    if (e !== model_edge) begin
      n_fail++;
      $display("FAIL stuck_latency: got %0d expected %0d", e, model_edge);
    end
    read_deck();
    for (int k = 0; k < NCARDS; k++) begin
      n_checks++;
      if (got_deck[k] !== exp_q[k]) begin
        n_fail++;
        $display("FAIL stuck_deck[%0d]: got %0d expected %0d", k, got_deck[k], exp_q[k]);
      end
    end
`else
    run_shuffle(1'b1, 0, 32'h1F, 1000, 0, e);
    n_checks++;
    if (e !== -1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL stuck_busy: got done_edge=%0d busy=%b expected -1 1", e, busy);
    end
    read_deck();
    for (int k = 0; k < NCARDS; k++) begin
      n_checks++;
      if (got_deck[k] !== IDXW'(k)) begin
        n_fail++;
        $display("FAIL stuck_deck[%0d]: got %0d expected %0d", k, got_deck[k], k);
      end
    end
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
`endif
  endtask

  task automatic test_back_to_back(input int count, input int mode);
    int e;
    int seen [NCARDS];
    bit perm_ok;
    for (int s = 0; s < count; s++) begin
      run_shuffle(1'b1, mode, 32'h0, 2000, 0, e);
      model_shuffle();
      n_checks++;
      if (e !== model_edge) begin
        n_fail++;
        $display("FAIL b2b_latency[%0d]: got %0d expected %0d", s, e, model_edge);
      end
      read_deck();
      for (int k = 0; k < NCARDS; k++) seen[k] = 0;
      for (int k = 0; k < NCARDS; k++) begin
        n_checks++;
        if (got_deck[k] !== exp_q[k]) begin
          n_fail++;
          $display("FAIL b2b_deck[%0d][%0d]: got %0d expected %0d", s, k, got_deck[k], exp_q[k]);
        end
        if (int'(got_deck[k]) < NCARDS) seen[int'(got_deck[k])]++;
      end
      perm_ok = 1'b1;
      for (int k = 0; k < NCARDS; k++) if (seen[k] != 1) perm_ok = 1'b0;
      n_checks++;
      if (perm_ok !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_perm[%0d]: got non-permutation expected permutation of 0..%0d", s, NCARDS - 1);
      end
    end
  endtask

  task automatic test_exclusive();
    n_checks++;
    if (both_seen !== 1'b0) begin
      n_fail++;
      $display("FAIL busy_done_exclusive: got both high expected never");
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    both_seen = 1'b0;
    lfsr = 32'h1D2C3B4A;
    test_reset();
    test_const_zero();
    test_const_one();
    test_restart();
    test_stuck();
    test_back_to_back(50, 1);
    test_back_to_back(4, 2);
    test_exclusive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
